sram_fifo_ctrl: RTL



---
 rtl/sram_fifo_ctrl_pkg.sv | 17 +
 rtl/sram_fifo_ptr.sv | 39 +++
 rtl/sram_fifo_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared sizing constants and helpers for the SRAM-backed FWFT FIFO controller.
package sram_fifo_ctrl_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int ADDR_WIDTH_DEF  = 6;
   localparam int ALMOST_FULL_DEF = 56;

   function automatic int depth_of(input int aw);
      return 32'sd1 << aw;
   endfunction

   // One extra bit so a full queue and an empty one have distinct pointer pairs.
   function automatic int ptr_width_of(input int aw);
      return aw + 32'sd1;
   endfunction

endpackage

// File: rtl/sram_fifo_ptr.sv
// Wrap-bit pointer register: increments on inc_i, clears on flush_i or reset.
module sram_fifo_ptr
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int PW = ptr_width_of(ADDR_WIDTH_DEF)
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          flush_i,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o,
   output logic [PW-1:0] ptr_inc_o
);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // ptr_inc_o ignores flush so the read side can steer the SRAM address from it.
   always_comb begin
      ptr_inc_o = ptr_q + PW'(inc_i);
      if (flush_i) begin
         ptr_d = {PW{1'b0}};
      end else begin
         ptr_d = ptr_inc_o;
      end
   end

   // Pointer state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= {PW{1'b0}};
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external dual-port SRAM
// whose read port is registered; out_data is the SRAM q output directly.
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int ALMOST_FULL = ALMOST_FULL_DEF
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_write_addr,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic [ADDR_WIDTH-1:0] ram_read_addr,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   localparam int PW = ptr_width_of(ADDR_WIDTH);
   localparam logic [PW-1:0] DEPTH_P = PW'(depth_of(ADDR_WIDTH));
   localparam logic [PW-1:0] AF_P    = PW'(ALMOST_FULL);

   logic [PW-1:0] wr_ptr_s;
   logic [PW-1:0] wr_ptr_inc_s;
   logic [PW-1:0] rd_ptr_s;
   logic [PW-1:0] rd_ptr_next_s;
   logic          full_s;
   logic          in_fire_s;
   logic          out_fire_s;
   logic          out_valid_q;
   logic          out_valid_d;

   sram_fifo_ptr #(.PW(PW)) u_wr_ptr (
      .clock    (clock),
      .reset_n  (reset_n),
      .flush_i  (flush),
      .inc_i    (in_fire_s),
      .ptr_o    (wr_ptr_s),
      .ptr_inc_o(wr_ptr_inc_s)
   );

   sram_fifo_ptr #(.PW(PW)) u_rd_ptr (
      .clock    (clock),
      .reset_n  (reset_n),
      .flush_i  (flush),
      .inc_i    (out_fire_s),
      .ptr_o    (rd_ptr_s),
      .ptr_inc_o(rd_ptr_next_s)
   );

   // Occupancy, handshakes and SRAM port steering.
   always_comb begin
      count          = wr_ptr_s - rd_ptr_s;
      full_s         = (count == DEPTH_P);
      almost_full    = (count >= AF_P);
      in_ready       = !full_s && !flush && reset_n;
      in_fire_s      = in_valid && in_ready;
      out_fire_s     = out_valid_q && out_ready;
      ram_we         = in_fire_s;
      ram_write_addr = wr_ptr_s[ADDR_WIDTH-1:0];
      ram_data       = in_data;
      ram_read_addr  = rd_ptr_next_s[ADDR_WIDTH-1:0];
      out_data       = ram_q;
      out_valid      = out_valid_q;
   end

   // Compare against the pre-edge write pointer: a word written this edge
   // becomes visible one edge later, once the SRAM has registered it.
   always_comb begin
      if (flush) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = (rd_ptr_next_s != wr_ptr_s);
      end
   end

   // Head-valid register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
      end
   end

   logic unused_s;
   assign unused_s = ^wr_ptr_inc_s;

endmodule
